// File: rtl/mult_div_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_pkg
//   Shared definitions for the E-stage multiply/divide unit. The controller
//   and hazard unit import this package for the same mdop encoding.
//   Holds:
//     md_op_e       4-bit mdop encoding
//     is_start_op   1 if the op launches a multi-cycle operation
//     is_div_op     1 if the op uses the divide latency
//   Optional feature macro: MDU_MADD_EN enables madd/maddu/msub as start ops.
// ---------------------------------------------------------------------------
package mult_div_pkg;

  typedef enum logic [3:0] {
    MdNone  = 4'h0,
    MdMult  = 4'h1,
    MdMultu = 4'h2,
    MdDiv   = 4'h3,
    MdDivu  = 4'h4,
    MdMthi  = 4'h5,
    MdMtlo  = 4'h6,
    MdMfhi  = 4'h7,
    MdMflo  = 4'h8,
    MdMadd  = 4'h9,
    MdMaddu = 4'hA,
    MdMsub  = 4'hB
  } md_op_e;

  function automatic logic is_start_op(md_op_e op);
    logic r;
    r = 1'b0;
    case (op)
      MdMult, MdMultu, MdDiv, MdDivu: r = 1'b1;
`ifdef MDU_MADD_EN
      MdMadd, MdMaddu, MdMsub:        r = 1'b1;
`endif
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_op(md_op_e op);
    return (op == MdDiv) || (op == MdDivu);
  endfunction

endpackage

// File: rtl/mult_div_calc.sv
// ---------------------------------------------------------------------------
// md_calc
//   Combinational result generator for the multiply/divide unit. Evaluated
//   on the latched operands; the top level samples it on the completion edge.
//   Ports:
//     i_a, i_b    latched operands (rs, rt)
//     i_op        latched operation
//     i_hi, i_lo  current HI/LO (accumulate base for the madd family)
//     o_result    {HI, LO} to be written
//     o_we        write enable; 0 on divide by zero
//   Optional feature macro: MDU_MADD_EN adds madd/maddu/msub.
// ---------------------------------------------------------------------------
module md_calc
  import mult_div_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  md_op_e      i_op,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [63:0] o_result,
  output logic        o_we
);

  logic               w_div_zero;
  logic [31:0]        w_divisor;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic [63:0]        w_acc;
  logic signed [32:0] w_sdividend;
  logic signed [32:0] w_sdivisor;
  logic [31:0]        w_squot;
  logic [31:0]        w_srem;
  logic [31:0]        w_uquot;
  logic [31:0]        w_urem;

  assign w_div_zero = (i_b == 32'd0);
  // Divisor forced to 1 on zero so the dividers never see an X-producing operand;
  // the result is discarded through o_we anyway.
  assign w_divisor  = w_div_zero ? 32'd1 : i_b;

  assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};
  assign w_acc    = {i_hi, i_lo};

  // 33-bit signed divide keeps -2^31 / -1 well defined (wraps to 0x80000000).
  assign w_sdividend = $signed({i_a[31], i_a});
  assign w_sdivisor  = $signed({w_divisor[31], w_divisor});
  assign w_squot     = 32'(w_sdividend / w_sdivisor);
  assign w_srem      = 32'(w_sdividend % w_sdivisor);
  assign w_uquot     = i_a / w_divisor;
  assign w_urem      = i_a % w_divisor;

  always_comb begin
    o_result = w_acc;
    o_we     = 1'b0;
    case (i_op)
      MdMult: begin
        o_result = $unsigned(w_prod_s);
        o_we     = 1'b1;
      end
      MdMultu: begin
        o_result = w_prod_u;
        o_we     = 1'b1;
      end
      MdDiv: begin
        o_result = {w_srem, w_squot};
        o_we     = !w_div_zero;
      end
      MdDivu: begin
        o_result = {w_urem, w_uquot};
        o_we     = !w_div_zero;
      end
`ifdef MDU_MADD_EN
      MdMadd: begin
        o_result = w_acc + $unsigned(w_prod_s);
        o_we     = 1'b1;
      end
      MdMaddu: begin
        o_result = w_acc + w_prod_u;
        o_we     = 1'b1;
      end
      MdMsub: begin
        o_result = w_acc - $unsigned(w_prod_s);
        o_we     = 1'b1;
      end
`endif
      default: begin
        o_result = w_acc;
        o_we     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mult_div.sv
// ---------------------------------------------------------------------------
// mult_div
//   Multi-cycle multiply/divide unit beside the E-stage ALU. Owns the
//   architectural HI/LO registers, the busy counter and the operand latches.
//   Ports:
//     clk        clock, all state on posedge
//     reset      synchronous active-high; clears HI, LO and the counter
//     data1_E    operand A (rs, forwarded)
//     data2_E    operand B (rt, forwarded)
//     mdop       operation code (mult_div_pkg::md_op_e)
//     start      1-cycle launch pulse for mult/multu/div/divu (madd family)
//     busy       operation in flight; hazard unit stalls md ops in D
//     data_md_E  HI on mfhi, LO on mflo, else 0 (combinational)
//   Parameters: MULT_CYCLES, DIV_CYCLES (busy duration, both >= 1).
//   Optional feature macro: MDU_MADD_EN enables madd/maddu/msub.
// ---------------------------------------------------------------------------
module mult_div
  import mult_div_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data1_E,
  input  logic [31:0] data2_E,
  input  logic [3:0]  mdop,
  input  logic        start,
  output logic        busy,
  output logic [31:0] data_md_E
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  md_op_e          w_op;
  logic            w_accept;
  logic [63:0]     w_result;
  logic            w_we;

  logic [CntW-1:0] r_cnt;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  md_op_e          r_op;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;

  assign w_op     = md_op_e'(mdop);
  assign w_accept = start && (r_cnt == '0) && is_start_op(w_op);
  // Start pulses with an illegal op never raise busy.
  assign busy     = (r_cnt != '0) || (start && is_start_op(w_op));

  md_calc u_md_calc (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_result (w_result),
    .o_we     (w_we)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= MdNone;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (w_accept) begin
      r_a   <= data1_E;
      r_b   <= data2_E;
      r_op  <= w_op;
      r_cnt <= is_div_op(w_op) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CntW'(1);
      // Completion on the 1->0 edge; mt* cannot collide since busy is still high here.
      if ((r_cnt == CntW'(1)) && w_we) begin
        r_hi <= w_result[63:32];
        r_lo <= w_result[31:0];
      end
    end else if (w_op == MdMthi) begin
      r_hi <= data1_E;
    end else if (w_op == MdMtlo) begin
      r_lo <= data1_E;
    end
  end

  always_comb begin
    data_md_E = 32'd0;
    case (w_op)
      MdMfhi:  data_md_E = r_hi;
      MdMflo:  data_md_E = r_lo;
      default: data_md_E = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mult_div.sv
module tb_mult_div;
  import mult_div_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data1_E;
  logic [31:0] data2_E;
  logic [3:0]  mdop;
  logic        start;
  logic        busy;
  logic [31:0] data_md_E;

  int total = 0;
  int bad   = 0;

  mult_div #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .data1_E   (data1_E),
    .data2_E   (data2_E),
    .mdop      (mdop),
    .start     (start),
    .busy      (busy),
    .data_md_E (data_md_E)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reads HI then LO through the output mux; call away from posedge.
  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    mdop = 4'h7;
    #1 hi = data_md_E;
    mdop = 4'h8;
    #1 lo = data_md_E;
    mdop = 4'h0;
    #1;
  endtask

  // Call at posedge+1. Returns busy in the start cycle and the number of busy
  // cycles after the accepting edge; ends at the negedge where busy dropped.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic busy0, output int ncyc);
    mdop    = op;
    data1_E = a;
    data2_E = b;
    start   = 1'b1;
    @(negedge clk);
    busy0 = busy;
    @(posedge clk);
    #1;
    start = 1'b0;
    mdop  = 4'h0;
    ncyc  = 0;
    @(negedge clk);
    while (busy && ncyc < 40) begin
      ncyc++;
      @(negedge clk);
    end
  endtask

  // Call at posedge+1; applies mthi/mtlo for one edge.
  task automatic mt_op(input logic [3:0] op, input logic [31:0] val);
    mdop    = op;
    data1_E = val;
    @(posedge clk);
    #1 mdop = 4'h0;
  endtask

  logic [31:0] hi, lo;
  logic        b0;
  int          n;

  initial begin
    reset = 1'b1; start = 1'b0; mdop = 4'h0; data1_E = '0; data2_E = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_mux_none", data_md_E, 32'd0);
    read_hilo(hi, lo);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    // mult -1 * -1
    @(posedge clk); #1;
    run_op(4'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, b0, n);
    chk("mult_busy_start", {31'd0, b0}, 32'd1);
    chk("mult_cycles", n, 32'd5);
    read_hilo(hi, lo);
    chk("mult_hi", hi, 32'h00000000);
    chk("mult_lo", lo, 32'h00000001);

    // multu 0xFFFFFFFF^2
    @(posedge clk); #1;
    run_op(4'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, b0, n);
    chk("multu_cycles", n, 32'd5);
    read_hilo(hi, lo);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    // div -7 / 2
    @(posedge clk); #1;
    run_op(4'h3, 32'hFFFFFFF9, 32'd2, b0, n);
    chk("div_busy_start", {31'd0, b0}, 32'd1);
    chk("div_cycles", n, 32'd10);
    read_hilo(hi, lo);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    // div 7 / -2: remainder keeps dividend sign
    @(posedge clk); #1;
    run_op(4'h3, 32'd7, 32'hFFFFFFFE, b0, n);
    read_hilo(hi, lo);
    chk("div_negb_lo", lo, 32'hFFFFFFFD);
    chk("div_negb_hi", hi, 32'h00000001);

    // divu 7 / 2
    @(posedge clk); #1;
    run_op(4'h4, 32'd7, 32'd2, b0, n);
    chk("divu_cycles", n, 32'd10);
    read_hilo(hi, lo);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    // mthi then mfhi
    @(posedge clk); #1;
    mt_op(4'h5, 32'h12345678);
    @(negedge clk);
    read_hilo(hi, lo);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo", lo, 32'd3);
    chk("mux_none_after_mthi", data_md_E, 32'd0);

    // divu by zero: full latency, HI/LO unchanged
    @(posedge clk); #1;
    run_op(4'h4, 32'd5, 32'd0, b0, n);
    chk("div0_cycles", n, 32'd10);
    read_hilo(hi, lo);
    chk("div0_hi", hi, 32'h12345678);
    chk("div0_lo", lo, 32'd3);

    // mult 3 * -2 with a div start at t+2 that must be ignored
    @(posedge clk); #1;
    mdop = 4'h1; data1_E = 32'd3; data2_E = 32'hFFFFFFFE; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mdop = 4'h0; data1_E = 32'd100; data2_E = 32'd7;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) begin
        mdop = 4'h3; start = 1'b1;
      end else begin
        mdop = 4'h0; start = 1'b0;
      end
      @(negedge clk);
      if (busy) n++;
      @(posedge clk); #1;
    end
    mdop = 4'h0; start = 1'b0;
    chk("ignored_start_cycles", n, 32'd5);
    read_hilo(hi, lo);
    chk("ignored_start_hi", hi, 32'hFFFFFFFF);
    chk("ignored_start_lo", lo, 32'hFFFFFFFA);

    // mtlo while busy (divu by zero, so no completion write masks it)
    @(posedge clk); #1;
    mdop = 4'h4; data1_E = 32'd9; data2_E = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mdop = 4'h6; data1_E = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1 mdop = 4'h0;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("mtlo_busy_drop", {31'd0, busy}, 32'd0);
    read_hilo(hi, lo);
    chk("mtlo_busy_lo", lo, 32'hFFFFFFFA);
    chk("mtlo_busy_hi", hi, 32'hFFFFFFFF);

    // reset in the middle of a div
    @(posedge clk); #1;
    mdop = 4'h3; data1_E = 32'd100; data2_E = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mdop = 4'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy_after", {31'd0, busy}, 32'd0);
    read_hilo(hi, lo);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    chk("rst_mid_busy_late", {31'd0, busy}, 32'd0);
    read_hilo(hi, lo);
    chk("rst_mid_hi_late", hi, 32'd0);
    chk("rst_mid_lo_late", lo, 32'd0);

    // maddu 1*1 onto HI:LO = 0:0xFFFFFFFF
    @(posedge clk); #1;
    mt_op(4'h5, 32'd0);
    mt_op(4'h6, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    run_op(4'hA, 32'd1, 32'd1, b0, n);
    chk("maddu_busy_start", {31'd0, b0}, 32'd1);
    chk("maddu_cycles", n, 32'd5);
    read_hilo(hi, lo);
    chk("maddu_hi", hi, 32'd1);
    chk("maddu_lo", lo, 32'd0);
`else
    mdop = 4'hA; data1_E = 32'd1; data2_E = 32'd1; start = 1'b1;
    @(negedge clk);
    chk("maddu_off_busy_start", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; mdop = 4'h0;
    @(negedge clk);
    chk("maddu_off_busy_next", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    read_hilo(hi, lo);
    chk("maddu_off_hi", hi, 32'd0);
    chk("maddu_off_lo", lo, 32'hFFFFFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
